mgmt_obi_arbiter: RTL and testbench



---
 rtl/mgmt_obi_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mgmt_obi_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_obi_arbiter.sv
// rtl/mgmt_obi_arbiter.sv - arbiter sharing one OBI manager port between imem and dmem managers
//
// Merges the management CPU instruction-fetch (imem) and data (dmem) OBI managers onto
// a single downstream OBI port. Round-robin between the two, with the selection locked
// while a forwarded request waits for gnt. An in-order ID FIFO routes each response
// back to the manager that issued the request.
//
// Configuration macro: MGMT_OBI_ARB_DMEM_PRIO_EN
//   defined   - dmem wins every unlocked tie (fixed priority)
//   undefined - round-robin on ties, imem wins the first tie after reset
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   imem_req_i     instruction-fetch manager request
//   imem_rsp_o     instruction-fetch manager response
//   dmem_req_i     data manager request
//   dmem_rsp_o     data manager response
//   mem_req_o      shared downstream request
//   mem_rsp_i      shared downstream response
//   outstanding_o  number of granted transactions awaiting rvalid
//   proto_err_o    one-cycle pulse on rvalid with nothing in flight

package mgmt_obi_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module mgmt_obi_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter type obi_req_t = mgmt_obi_arbiter_pkg::obi_req_t,
    parameter type obi_rsp_t = mgmt_obi_arbiter_pkg::obi_rsp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  obi_req_t                              imem_req_i,
    output obi_rsp_t                              imem_rsp_o,
    input  obi_req_t                              dmem_req_i,
    output obi_rsp_t                              dmem_rsp_o,
    output obi_req_t                              mem_req_o,
    input  obi_rsp_t                              mem_rsp_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  proto_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic                      lock_q, lock_d;
    logic                      sel_q, sel_d;
    logic                      last_q, last_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wptr_q, wptr_d;
    logic [PtrW-1:0]           rptr_q, rptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;

    logic     sel;
    obi_req_t sel_req;
    logic     full;
    logic     hs;
    logic     pop;
    logic     head;

    // Requester selection: 0 = imem, 1 = dmem.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            // Hold the waiting request so its address stays stable until gnt.
            sel = sel_q;
        end else if (imem_req_i.req && dmem_req_i.req) begin
`ifdef MGMT_OBI_ARB_DMEM_PRIO_EN
            sel = 1'b1;
`else
            sel = ~last_q;
`endif
        end else begin
            sel = dmem_req_i.req;
        end
    end

    assign sel_req = sel ? dmem_req_i : imem_req_i;
    // Full uses the registered count, so rvalid never reaches mem_req_o.req.
    assign full    = (cnt_q == CntMax);
    assign pop     = mem_rsp_i.rvalid && (cnt_q != '0) && !rst_i;
    assign head    = fifo_q[rptr_q];
    assign hs      = mem_req_o.req && mem_rsp_i.gnt;

    // Forwarding, grant and response routing.
    always_comb begin
        mem_req_o  = '0;
        imem_rsp_o = '0;
        dmem_rsp_o = '0;
        if (sel_req.req) begin
            mem_req_o.a   = sel_req.a;
            mem_req_o.req = !full && !rst_i;
        end
        imem_rsp_o.gnt = mem_req_o.req && mem_rsp_i.gnt && !sel;
        dmem_rsp_o.gnt = mem_req_o.req && mem_rsp_i.gnt && sel;
        if (pop) begin
            if (head) begin
                dmem_rsp_o.rvalid = 1'b1;
                dmem_rsp_o.r      = mem_rsp_i.r;
            end else begin
                imem_rsp_o.rvalid = 1'b1;
                imem_rsp_o.r      = mem_rsp_i.r;
            end
        end
    end

    assign proto_err_o   = mem_rsp_i.rvalid && (cnt_q == '0) && !rst_i;
    assign outstanding_o = cnt_q;

    // Next-state: lock, round-robin history and the in-order ID FIFO.
    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        last_d = last_q;
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (hs) begin
            lock_d         = 1'b0;
            last_d         = sel;
            fifo_d[wptr_q] = sel;
            wptr_d         = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
        end else if (mem_req_o.req) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
            last_q <= 1'b1;
            fifo_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            sel_q  <= sel_d;
            last_q <= last_d;
            fifo_q <= fifo_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mgmt_obi_arbiter.sv
// tb/tb_mgmt_obi_arbiter.sv - scoreboard testbench for mgmt_obi_arbiter
module tb_mgmt_obi_arbiter;
    import mgmt_obi_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    obi_req_t   imem_req, dmem_req, mem_req;
    obi_rsp_t   imem_rsp, dmem_rsp, mem_rsp;
    logic [1:0] outstanding;
    logic       proto_err;

    always #5 clk = ~clk;

    mgmt_obi_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_i   (imem_req),
        .imem_rsp_o   (imem_rsp),
        .dmem_req_i   (dmem_req),
        .dmem_rsp_o   (dmem_rsp),
        .mem_req_o    (mem_req),
        .mem_rsp_i    (mem_rsp),
        .outstanding_o(outstanding),
        .proto_err_o  (proto_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          id;
        logic [31:0] val;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    int   perr_pending = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (imem_rsp.gnt || dmem_rsp.gnt) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", {30'd0, imem_rsp.gnt, dmem_rsp.gnt}, 32'd0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_id", {30'd0, imem_rsp.gnt, dmem_rsp.gnt}, e.id ? 32'd1 : 32'd2);
                    check("gnt_addr", mem_req.a.addr, e.val);
                end
            end
            if (imem_rsp.rvalid || dmem_rsp.rvalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, imem_rsp.rvalid, dmem_rsp.rvalid}, 32'd0);
                end else begin
                    e = rq.pop_front();
                    check("rsp_id", {30'd0, imem_rsp.rvalid, dmem_rsp.rvalid}, e.id ? 32'd1 : 32'd2);
                    check("rsp_data", e.id ? dmem_rsp.r.rdata : imem_rsp.r.rdata, e.val);
                    check("rsp_other_zero", e.id ? imem_rsp.r.rdata : dmem_rsp.r.rdata, 32'd0);
                end
            end
            if (proto_err || perr_pending > 0) begin
                check("proto_err", {31'd0, proto_err}, (perr_pending > 0) ? 32'd1 : 32'd0);
                if (perr_pending > 0) perr_pending--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic obi_req_t mk(input bit req, input logic [31:0] addr);
        obi_req_t r;
        r        = '0;
        r.req    = req;
        r.a.addr = addr;
        r.a.be   = 4'hf;
        return r;
    endfunction

    task automatic drive_rsp(input bit gnt, input bit rv, input logic [31:0] data);
        mem_rsp         = '0;
        mem_rsp.gnt     = gnt;
        mem_rsp.rvalid  = rv;
        mem_rsp.r.rdata = data;
    endtask

    task automatic exp_gnt(input bit id, input logic [31:0] addr);
        exp_t e;
        e.id  = id;
        e.val = addr;
        gq.push_back(e);
    endtask

    task automatic exp_rsp(input bit id, input logic [31:0] data);
        exp_t e;
        e.id  = id;
        e.val = data;
        rq.push_back(e);
    endtask

    task automatic do_reset();
        imem_req = '0;
        dmem_req = '0;
        mem_rsp  = '0;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    task automatic drain_check(input string name);
        check({name, "_gnt_left"}, 32'(gq.size()), 32'd0);
        check({name, "_rsp_left"}, 32'(rq.size()), 32'd0);
        check({name, "_perr_left"}, 32'(perr_pending), 32'd0);
    endtask

    initial begin
        bit prev_id;
        bit cur_id;

        // Imem only, three back-to-back fetches.
        do_reset();
        check("reset_cnt", {30'd0, outstanding}, 32'd0);
        check("reset_req", {31'd0, mem_req.req}, 32'd0);
        check("reset_perr", {31'd0, proto_err}, 32'd0);
        imem_req = mk(1, 32'h100); drive_rsp(1, 0, 0); exp_gnt(0, 32'h100);
        tick();
        imem_req = mk(1, 32'h104); drive_rsp(1, 1, 32'h1111_0000);
        exp_gnt(0, 32'h104); exp_rsp(0, 32'h1111_0000);
        settle(); check("s1_cnt_c1", {30'd0, outstanding}, 32'd1);
        tick();
        imem_req = mk(1, 32'h108); drive_rsp(1, 1, 32'h1111_0001);
        exp_gnt(0, 32'h108); exp_rsp(0, 32'h1111_0001);
        settle(); check("s1_cnt_c2", {30'd0, outstanding}, 32'd1);
        tick();
        imem_req = '0; drive_rsp(0, 1, 32'h1111_0002); exp_rsp(0, 32'h1111_0002);
        settle(); check("s1_cnt_c3", {30'd0, outstanding}, 32'd1);
        tick();
        drive_rsp(0, 0, 0);
        settle(); check("s1_cnt_end", {30'd0, outstanding}, 32'd0);
        drain_check("s1");

        // Continuous contention, gnt always high.
        do_reset();
        prev_id = 0;
        for (int i = 0; i < 4; i++) begin
            imem_req = mk(1, 32'h200);
            dmem_req = mk(1, 32'h300);
`ifdef MGMT_OBI_ARB_DMEM_PRIO_EN
            cur_id = 1'b1;
`else
            cur_id = (i % 2) == 1;
`endif
            exp_gnt(cur_id, cur_id ? 32'h300 : 32'h200);
            if (i > 0) begin
                drive_rsp(1, 1, 32'hA0 + 32'(i - 1));
                exp_rsp(prev_id, 32'hA0 + 32'(i - 1));
            end else begin
                drive_rsp(1, 0, 0);
            end
            prev_id = cur_id;
            tick();
        end
        imem_req = '0; dmem_req = '0;
        drive_rsp(0, 1, 32'hA3); exp_rsp(prev_id, 32'hA3);
        settle(); check("s2_cnt", {30'd0, outstanding}, 32'd1);
        tick();
        drive_rsp(0, 0, 0);
        settle(); check("s2_cnt_end", {30'd0, outstanding}, 32'd0);
        drain_check("s2");

        // Lock: imem waits three cycles for gnt while dmem arrives.
        do_reset();
        imem_req = mk(1, 32'h400); drive_rsp(0, 0, 0);
        settle();
        check("lock_req_c0", {31'd0, mem_req.req}, 32'd1);
        check("lock_addr_c0", mem_req.a.addr, 32'h400);
        tick();
        dmem_req = mk(1, 32'h500);
        settle(); check("lock_addr_c1", mem_req.a.addr, 32'h400);
        tick();
        settle(); check("lock_addr_c2", mem_req.a.addr, 32'h400);
        tick();
        drive_rsp(1, 0, 0); exp_gnt(0, 32'h400);
        tick();
        imem_req = '0; exp_gnt(1, 32'h500);
        settle(); check("lock_cnt_c4", {30'd0, outstanding}, 32'd1);
        tick();
        dmem_req = '0; drive_rsp(0, 1, 32'hB0); exp_rsp(0, 32'hB0);
        settle(); check("lock_cnt_c5", {30'd0, outstanding}, 32'd2);
        tick();
        drive_rsp(0, 1, 32'hB1); exp_rsp(1, 32'hB1);
        tick();
        drive_rsp(0, 0, 0);
        settle(); check("lock_cnt_end", {30'd0, outstanding}, 32'd0);
        drain_check("s3");

        // Full tracker blocks requests; simultaneous push and pop.
        do_reset();
        imem_req = mk(1, 32'h600); drive_rsp(1, 0, 0); exp_gnt(0, 32'h600);
        tick();
        imem_req = '0; dmem_req = mk(1, 32'h700); exp_gnt(1, 32'h700);
        tick();
        dmem_req = '0; imem_req = mk(1, 32'h604);
        settle();
        check("full_req_blocked", {31'd0, mem_req.req}, 32'd0);
        check("full_cnt", {30'd0, outstanding}, 32'd2);
        tick();
        drive_rsp(1, 1, 32'hC0); exp_rsp(0, 32'hC0);
        settle(); check("full_req_blocked_rv", {31'd0, mem_req.req}, 32'd0);
        tick();
        drive_rsp(1, 1, 32'hC1); exp_rsp(1, 32'hC1); exp_gnt(0, 32'h604);
        settle();
        check("pushpop_req", {31'd0, mem_req.req}, 32'd1);
        check("pushpop_cnt_before", {30'd0, outstanding}, 32'd1);
        tick();
        imem_req = '0; drive_rsp(0, 1, 32'hC2); exp_rsp(0, 32'hC2);
        settle(); check("pushpop_cnt_after", {30'd0, outstanding}, 32'd1);
        tick();
        drive_rsp(0, 0, 0);
        settle(); check("full_cnt_end", {30'd0, outstanding}, 32'd0);
        drain_check("s4");

        // Rvalid with nothing in flight.
        do_reset();
        drive_rsp(0, 1, 32'hDEAD); perr_pending = 1;
        settle();
        check("perr_imem_rv", {31'd0, imem_rsp.rvalid}, 32'd0);
        check("perr_dmem_rv", {31'd0, dmem_rsp.rvalid}, 32'd0);
        tick();
        drive_rsp(0, 0, 0);
        tick();
        check("perr_cnt", {30'd0, outstanding}, 32'd0);
        drain_check("s5");

        // Reset with two transactions in flight.
        do_reset();
        imem_req = mk(1, 32'h800); drive_rsp(1, 0, 0); exp_gnt(0, 32'h800);
        tick();
        imem_req = '0; dmem_req = mk(1, 32'h900); exp_gnt(1, 32'h900);
        tick();
        settle(); check("rst_pre_cnt", {30'd0, outstanding}, 32'd2);
        imem_req = mk(1, 32'h804); dmem_req = mk(1, 32'h904); drive_rsp(1, 1, 32'hE0);
        rst = 1'b1;
        settle();
        check("rst_req", {31'd0, mem_req.req}, 32'd0);
        check("rst_gnt", {30'd0, imem_rsp.gnt, dmem_rsp.gnt}, 32'd0);
        check("rst_rvalid", {30'd0, imem_rsp.rvalid, dmem_rsp.rvalid}, 32'd0);
        check("rst_cnt", {30'd0, outstanding}, 32'd0);
        check("rst_perr", {31'd0, proto_err}, 32'd0);
        tick();
        tick();
        imem_req = '0; dmem_req = '0; drive_rsp(0, 0, 0);
        rst = 1'b0;
        tick();
        drive_rsp(0, 1, 32'hE1); perr_pending = 1;
        tick();
        drive_rsp(0, 0, 0);
        tick();
        check("rst_post_cnt", {30'd0, outstanding}, 32'd0);
        drain_check("s6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
